// File: rtl/traffic_safety_monitor_if.sv
// Controller-to-lamp bus for traffic_safety_monitor: controller colours, tick and
// fault clear flow in; registered lamp drive and fault status flow out.
interface traffic_safety_monitor_if;
  logic       tick;
  logic       ns_g, ns_y, ns_r;
  logic       ew_g, ew_y, ew_r;
  logic       clr_fault;
  logic       lamp_ns_g, lamp_ns_y, lamp_ns_r;
  logic       lamp_ew_g, lamp_ew_y, lamp_ew_r;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output tick, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, clr_fault,
    input  lamp_ns_g, lamp_ns_y, lamp_ns_r, lamp_ew_g, lamp_ew_y, lamp_ew_r,
    input  fault, fault_code
  );

  modport slave (
    input  tick, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, clr_fault,
    output lamp_ns_g, lamp_ns_y, lamp_ns_r, lamp_ew_g, lamp_ew_y, lamp_ew_r,
    output fault, fault_code
  );
endinterface

// File: rtl/traffic_safety_monitor.sv
// Lamp-side safety monitor: checks controller colours for legality, sequence and
// phase duration, then drives lamps. Optional macro TSM_FLASH_EN flashes reds in FAULT.
module traffic_safety_monitor #(
  parameter int unsigned G_TICKS = 5,
  parameter int unsigned Y_TICKS = 2
) (
  input logic                     clk,
  input logic                     rst,
  traffic_safety_monitor_if.slave bus
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FAULT = 2'd1, ST_SYNC = 2'd2} state_e;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_ONEHOT   = 3'd1;
  localparam logic [2:0] CODE_CONFLICT = 3'd2;
  localparam logic [2:0] CODE_SEQ      = 3'd3;
  localparam logic [2:0] CODE_TIMING   = 3'd4;
  localparam logic [2:0] COL_G         = 3'b100;
  localparam logic [2:0] COL_Y         = 3'b010;
  localparam logic [2:0] COL_R         = 3'b001;
  localparam logic [5:0] LAMPS_RESET   = 6'b100_001;
  localparam logic [5:0] LAMPS_RED     = 6'b001_001;
  localparam logic [3:0] G_LIM         = 4'(G_TICKS);
  localparam logic [3:0] Y_LIM         = 4'(Y_TICKS);

  function automatic logic onehot3(input logic [2:0] c);
    return (c == COL_G) || (c == COL_Y) || (c == COL_R);
  endfunction

  function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
    return ((p == COL_G) && (c == COL_Y)) || ((p == COL_Y) && (c == COL_R)) ||
           ((p == COL_R) && (c == COL_G));
  endfunction

  state_e     state_q, state_d;
  logic [2:0] prev_ns_q, prev_ns_d, prev_ew_q, prev_ew_d;
  logic [3:0] phase_cnt_q, phase_cnt_d;
  logic [5:0] lamp_q, lamp_d;
  logic       fault_q, fault_d;
  logic [2:0] fault_code_q, fault_code_d;
  logic [2:0] code_s;
  logic       fault_red_s;

  logic [2:0] cur_ns_s, cur_ew_s;
  logic       onehot_bad_s, conflict_bad_s, seq_bad_s, timing_bad_s;
  logic       ns_enter_s, ew_enter_s, ns_exit_s, ew_exit_s, handover_s, phase_chg_s;
  logic       clr_ok_s;
  logic [3:0] limit_s;

  assign cur_ns_s       = {bus.ns_g, bus.ns_y, bus.ns_r};
  assign cur_ew_s       = {bus.ew_g, bus.ew_y, bus.ew_r};
  assign onehot_bad_s   = !onehot3(cur_ns_s) || !onehot3(cur_ew_s);
  assign conflict_bad_s = (bus.ns_r == bus.ew_r);
  assign clr_ok_s       = bus.clr_fault && !onehot_bad_s && !conflict_bad_s;
  assign phase_chg_s    = (cur_ns_s != prev_ns_q) || (cur_ew_s != prev_ew_q);
  assign ns_enter_s     = (prev_ns_q == COL_R) && (cur_ns_s == COL_G);
  assign ew_enter_s     = (prev_ew_q == COL_R) && (cur_ew_s == COL_G);
  assign ns_exit_s      = (prev_ns_q == COL_Y) && (cur_ns_s == COL_R);
  assign ew_exit_s      = (prev_ew_q == COL_Y) && (cur_ew_s == COL_R);
  assign handover_s     = (ns_enter_s && ew_exit_s) || (ew_enter_s && ns_exit_s);
  assign seq_bad_s      = ((cur_ns_s != prev_ns_q) && !legal_step(prev_ns_q, cur_ns_s)) ||
                          ((cur_ew_s != prev_ew_q) && !legal_step(prev_ew_q, cur_ew_s)) ||
                          (ns_enter_s && !ew_exit_s) || (ew_enter_s && !ns_exit_s);
  // The active phase is whichever direction was not red on the previous cycle.
  assign limit_s        = ((prev_ns_q == COL_G) || (prev_ew_q == COL_G)) ? G_LIM : Y_LIM;
  assign timing_bad_s   = phase_chg_s ? (phase_cnt_q != limit_s)
                                      : (bus.tick && (phase_cnt_q >= limit_s));

  // Lowest code wins when several checks fail together.
  always_comb begin
    if (onehot_bad_s) begin
      code_s = CODE_ONEHOT;
    end else if (conflict_bad_s) begin
      code_s = CODE_CONFLICT;
    end else if (seq_bad_s) begin
      code_s = CODE_SEQ;
    end else if (timing_bad_s) begin
      code_s = CODE_TIMING;
    end else begin
      code_s = CODE_NONE;
    end
  end

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      prev_ns_q    <= COL_G;
      prev_ew_q    <= COL_R;
      phase_cnt_q  <= 4'd0;
      lamp_q       <= LAMPS_RESET;
      fault_q      <= 1'b0;
      fault_code_q <= CODE_NONE;
    end else begin
      state_q      <= state_d;
      prev_ns_q    <= prev_ns_d;
      prev_ew_q    <= prev_ew_d;
      phase_cnt_q  <= phase_cnt_d;
      lamp_q       <= lamp_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (code_s != CODE_NONE) state_d = ST_FAULT;
        else                     state_d = ST_RUN;
      end
      ST_FAULT: begin
        if (clr_ok_s) state_d = ST_SYNC;
        else          state_d = ST_FAULT;
      end
      ST_SYNC: begin
        if (onehot_bad_s || conflict_bad_s) state_d = ST_FAULT;
        else if (handover_s)                state_d = ST_RUN;
        else                                state_d = ST_SYNC;
      end
      default: state_d = ST_FAULT;
    endcase
  end

`ifdef TSM_FLASH_EN
  logic flash_q, flash_d;

  // Red flash phase: lit on fault entry and in SYNC, toggled by ticks while held in FAULT.
  always_comb begin
    if ((state_q == ST_FAULT) && (state_d == ST_FAULT)) begin
      if (bus.tick) flash_d = !flash_q;
      else          flash_d = flash_q;
    end else begin
      flash_d = 1'b1;
    end
  end

  // Flash phase register.
  always_ff @(posedge clk) begin
    if (rst) flash_q <= 1'b1;
    else     flash_q <= flash_d;
  end

  assign fault_red_s = flash_d;
`else
  assign fault_red_s = 1'b1;
`endif

  // Output and datapath next values.
  always_comb begin
    prev_ns_d    = cur_ns_s;
    prev_ew_d    = cur_ew_s;
    phase_cnt_d  = phase_cnt_q;
    lamp_d       = LAMPS_RED;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_RUN: begin
        if (code_s != CODE_NONE) begin
          fault_d      = 1'b1;
          fault_code_d = code_s;
        end else begin
          lamp_d = {cur_ns_s, cur_ew_s};
          if (phase_chg_s)   phase_cnt_d = {3'd0, bus.tick};
          else if (bus.tick) phase_cnt_d = phase_cnt_q + 4'd1;
          else               phase_cnt_d = phase_cnt_q;
        end
      end
      ST_FAULT: begin
        if (clr_ok_s) begin
          fault_d      = 1'b0;
          fault_code_d = CODE_NONE;
        end else begin
          lamp_d = {2'b00, fault_red_s, 2'b00, fault_red_s};
        end
      end
      ST_SYNC: begin
        if (onehot_bad_s || conflict_bad_s) begin
          fault_d      = 1'b1;
          fault_code_d = onehot_bad_s ? CODE_ONEHOT : CODE_CONFLICT;
        end else if (handover_s) begin
          lamp_d      = {cur_ns_s, cur_ew_s};
          phase_cnt_d = {3'd0, bus.tick};
        end else begin
          lamp_d = LAMPS_RED;
        end
      end
      default: fault_d = 1'b1;
    endcase
  end

  assign {bus.lamp_ns_g, bus.lamp_ns_y, bus.lamp_ns_r} = lamp_q[5:3];
  assign {bus.lamp_ew_g, bus.lamp_ew_y, bus.lamp_ew_r} = lamp_q[2:0];
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;

endmodule
